// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : pipeline interlock, forwarding select and hazard event counters
// Rev 1.0
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_useRs,
    input  logic        id_useRt,
    input  logic        id_isBranch,
    input  logic        id_branchTaken,
    input  logic        ex_rfWE,
    input  logic [4:0]  ex_rfDst,
    input  logic        ex_isLoad,
    input  logic        mem_rfWE,
    input  logic [4:0]  mem_rfDst,
    input  logic        mem_isLoad,
    input  logic        mem_busy,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic        freeze,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        STALL2 = 1'b1
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state;
    state_t      next_state;
    state_t      eff_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt;
    logic ex_hit, mem_hit;
    logic load_use, br_alu, br_load, br_memload, hazard;

    always_comb begin
        ex_match_rs  = ex_rfWE  && (ex_rfDst  != 5'd0) && id_useRs && (ex_rfDst  == id_rs);
        ex_match_rt  = ex_rfWE  && (ex_rfDst  != 5'd0) && id_useRt && (ex_rfDst  == id_rt);
        mem_match_rs = mem_rfWE && (mem_rfDst != 5'd0) && id_useRs && (mem_rfDst == id_rs);
        mem_match_rt = mem_rfWE && (mem_rfDst != 5'd0) && id_useRt && (mem_rfDst == id_rt);
        ex_hit       = ex_match_rs  || ex_match_rt;
        mem_hit      = mem_match_rs || mem_match_rt;
        load_use     = ex_hit && ex_isLoad;
        br_alu       = id_isBranch && ex_hit && !ex_isLoad;
        br_load      = id_isBranch && ex_hit && ex_isLoad;
        br_memload   = id_isBranch && mem_hit && mem_isLoad;
        hazard       = load_use || br_alu || br_memload;
    end

    // Reset overrides the state register so outputs already follow RUN rules
    // in the reset cycle, cutting short any pending second bubble.
    assign eff_state = rst ? RUN : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = eff_state;
        stall      = 1'b0;
        freeze     = mem_busy;
        if (!mem_busy) begin
            case (eff_state)
                RUN: begin
                    stall = hazard;
                    if (br_load) begin
                        next_state = STALL2;
                    end
                end
                STALL2: begin
                    stall      = 1'b1;
                    next_state = RUN;
                end
                default: next_state = RUN;
            endcase
        end
        bubble = stall;
        flush  = id_branchTaken && !stall && !mem_busy;
    end

    // A loading EX producer cannot be forwarded, so it falls through to MEM.
    always_comb begin
        fwdA = 2'd0;
        fwdB = 2'd0;
        if (ex_match_rs && !ex_isLoad) begin
            fwdA = 2'd1;
        end else if (mem_match_rs) begin
            fwdA = 2'd2;
        end
        if (ex_match_rt && !ex_isLoad) begin
            fwdB = 2'd1;
        end else if (mem_match_rt) begin
            fwdB = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall && !freeze && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign stallCnt = stall_cnt;
    assign flushCnt = flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt;
    logic        id_useRs, id_useRt, id_isBranch, id_branchTaken;
    logic        ex_rfWE, ex_isLoad, mem_rfWE, mem_isLoad, mem_busy;
    logic [4:0]  ex_rfDst, mem_rfDst;
    logic        stall, bubble, flush, freeze;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stallCnt, flushCnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
        .id_isBranch(id_isBranch), .id_branchTaken(id_branchTaken),
        .ex_rfWE(ex_rfWE), .ex_rfDst(ex_rfDst), .ex_isLoad(ex_isLoad),
        .mem_rfWE(mem_rfWE), .mem_rfDst(mem_rfDst), .mem_isLoad(mem_isLoad),
        .mem_busy(mem_busy),
        .stall(stall), .bubble(bubble), .flush(flush), .freeze(freeze),
        .fwdA(fwdA), .fwdB(fwdB), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 5'd0; id_rt = 5'd0; id_useRs = 1'b0; id_useRt = 1'b0;
        id_isBranch = 1'b0; id_branchTaken = 1'b0;
        ex_rfWE = 1'b0; ex_rfDst = 5'd0; ex_isLoad = 1'b0;
        mem_rfWE = 1'b0; mem_rfDst = 5'd0; mem_isLoad = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic load_use_r8(input logic br);
        clr();
        ex_rfWE = 1'b1; ex_isLoad = 1'b1; ex_rfDst = 5'd8;
        id_rs = 5'd8; id_useRs = 1'b1; id_isBranch = br;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_stallCnt", stallCnt, 16'd0);
        chk("rst_flushCnt", flushCnt, 16'd0);
        chk("idle_stall", {15'd0, stall}, 16'd0);
        chk("idle_flush", {15'd0, flush}, 16'd0);

        // load-use: one bubble
        load_use_r8(1'b0); #1;
        chk("lu_stall", {15'd0, stall}, 16'd1);
        chk("lu_bubble", {15'd0, bubble}, 16'd1);
        chk("lu_fwdA", {14'd0, fwdA}, 16'd0);
        step(); clr(); #1;
        chk("lu_done", {15'd0, stall}, 16'd0);
        chk("lu_cnt", stallCnt, 16'd1);

        // branch on load: two bubbles, second independent of inputs
        load_use_r8(1'b1); #1;
        chk("bl_stall1", {15'd0, stall}, 16'd1);
        step(); clr(); #1;
        chk("bl_stall2", {15'd0, stall}, 16'd1);
        chk("bl_bubble2", {15'd0, bubble}, 16'd1);
        chk("bl_cnt2", stallCnt, 16'd2);
        step(); #1;
        chk("bl_done", {15'd0, stall}, 16'd0);
        chk("bl_cnt3", stallCnt, 16'd3);

        // forwarding priority and qualification
        clr();
        ex_rfWE = 1'b1; ex_rfDst = 5'd5; mem_rfWE = 1'b1; mem_rfDst = 5'd5;
        id_rt = 5'd5; id_useRt = 1'b1; #1;
        chk("fwdB_ex", {14'd0, fwdB}, 16'd1);
        chk("fwd_nostall", {15'd0, stall}, 16'd0);
        ex_rfWE = 1'b0; #1;
        chk("fwdB_mem", {14'd0, fwdB}, 16'd2);
        id_rs = 5'd5; id_useRs = 1'b1; #1;
        chk("fwdA_mem", {14'd0, fwdA}, 16'd2);
        id_useRt = 1'b0; #1;
        chk("fwdB_nouse", {14'd0, fwdB}, 16'd0);
        ex_rfWE = 1'b1; ex_rfDst = 5'd0; mem_rfDst = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_useRt = 1'b1; #1;
        chk("fwdA_r0", {14'd0, fwdA}, 16'd0);
        chk("fwdB_r0", {14'd0, fwdB}, 16'd0);

        // taken branch: flush unless stalled
        clr(); id_branchTaken = 1'b1; #1;
        chk("bt_flush", {15'd0, flush}, 16'd1);
        step(); #1;
        chk("bt_flushCnt", flushCnt, 16'd1);
        load_use_r8(1'b0); id_branchTaken = 1'b1; #1;
        chk("bt_lu_flush", {15'd0, flush}, 16'd0);
        chk("bt_lu_stall", {15'd0, stall}, 16'd1);
        step(); #1;
        chk("bt_lu_stallCnt", stallCnt, 16'd4);
        chk("bt_lu_flushCnt", flushCnt, 16'd1);

        // branch on ALU result in EX
        clr();
        ex_rfWE = 1'b1; ex_rfDst = 5'd9; id_rs = 5'd9; id_useRs = 1'b1; id_isBranch = 1'b1; #1;
        chk("balu_stall", {15'd0, stall}, 16'd1);
        chk("balu_fwdA", {14'd0, fwdA}, 16'd1);
        step(); clr(); #1;
        chk("balu_one", {15'd0, stall}, 16'd0);
        chk("balu_cnt", stallCnt, 16'd5);

        // branch on load in MEM; non-branch consumer does not stall
        mem_rfWE = 1'b1; mem_isLoad = 1'b1; mem_rfDst = 5'd3;
        id_rt = 5'd3; id_useRt = 1'b1; #1;
        chk("mload_nobr", {15'd0, stall}, 16'd0);
        id_isBranch = 1'b1; #1;
        chk("bmload_stall", {15'd0, stall}, 16'd1);
        chk("bmload_fwdB", {14'd0, fwdB}, 16'd2);
        step(); clr(); #1;
        chk("bmload_cnt", stallCnt, 16'd6);

        // freeze while in STALL2 holds state and counters
        load_use_r8(1'b1); step(); clr();
        mem_busy = 1'b1; id_branchTaken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_freeze", {15'd0, freeze}, 16'd1);
            chk("frz_stall", {15'd0, stall}, 16'd0);
            chk("frz_flush", {15'd0, flush}, 16'd0);
            step();
            chk("frz_cnt", stallCnt, 16'd7);
        end
        clr(); #1;
        chk("frz_resume", {15'd0, stall}, 16'd1);
        step(); #1;
        chk("frz_cnt_after", stallCnt, 16'd8);
        chk("frz_run", {15'd0, stall}, 16'd0);
        chk("frz_flushCnt", flushCnt, 16'd1);

        // freeze in RUN masks a hazard
        load_use_r8(1'b0); mem_busy = 1'b1; #1;
        chk("frz_run_stall", {15'd0, stall}, 16'd0);
        step();
        chk("frz_run_cnt", stallCnt, 16'd8);

        // reset during STALL2 aborts the second bubble
        load_use_r8(1'b1); step(); clr();
        chk("rs2_cnt", stallCnt, 16'd9);
        rst = 1'b1;
        ex_rfWE = 1'b1; ex_rfDst = 5'd6; id_rs = 5'd6; id_useRs = 1'b1; #1;
        chk("rs2_stall", {15'd0, stall}, 16'd0);
        chk("rs2_fwdA", {14'd0, fwdA}, 16'd1);
        step();
        rst = 1'b0; clr(); #1;
        chk("rs2_stallCnt0", stallCnt, 16'd0);
        chk("rs2_run", {15'd0, stall}, 16'd0);

        // stall counter saturation
        load_use_r8(1'b0);
        for (int i = 0; i < 65536; i++) step();
        chk("sat_stall", stallCnt, 16'hFFFF);
        step();
        chk("sat_stall_hold", stallCnt, 16'hFFFF);
        clr();

        // flush counter saturation from a preloaded value
        @(negedge clk);
        force dut.flush_cnt = 16'hFFFE;
        #1;
        release dut.flush_cnt;
        id_branchTaken = 1'b1;
        step();
        chk("sat_flush", flushCnt, 16'hFFFF);
        step();
        chk("sat_flush_hold", flushCnt, 16'hFFFF);
        clr();

        rst = 1'b1; step(); rst = 1'b0; #1;
        chk("final_rst_stall", stallCnt, 16'd0);
        chk("final_rst_flush", flushCnt, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
